// File: rtl/reg_file_2r1w_if.sv
// Operand/write bus between decode and the 2-read/1-write register file.
// master drives selects, enables, write data and stack ops; slave returns data and flags.
interface reg_file_2r1w_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 6
);
    logic             rd_en_a;
    logic [SEL_W-1:0] rd_sel_a;
    logic [WIDTH-1:0] rd_data_a;
    logic             rd_en_b;
    logic [SEL_W-1:0] rd_sel_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       sp_op;
    logic             wr_err;
    logic [WIDTH-1:0] sp_out;
    logic [WIDTH-1:0] dbg_out;

    modport master (
        output rd_en_a, rd_sel_a, rd_en_b, rd_sel_b,
        output wr_en, wr_sel, wr_data, sp_op,
        input  rd_data_a, rd_data_b, wr_err, sp_out, dbg_out
    );

    modport slave (
        input  rd_en_a, rd_sel_a, rd_en_b, rd_sel_b,
        input  wr_en, wr_sel, wr_data, sp_op,
        output rd_data_a, rd_data_b, wr_err, sp_out, dbg_out
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two registered read ports, one write port, read-only constants, write-first
// bypass and an in-place stack-pointer increment/decrement.
module reg_file_2r1w #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int SEL_W     = 6,
    parameter int NUM_CONST = 4,
    parameter int SP_IDX    = 4,
    parameter int DBG_IDX   = 8
) (
    input logic            clk,
    input logic            clear,
    reg_file_2r1w_if.slave bus
);
    localparam logic [SEL_W:0]   DEPTH_L     = (SEL_W+1)'(DEPTH);
    localparam logic [SEL_W:0]   NUM_CONST_L = (SEL_W+1)'(NUM_CONST);
    localparam logic [SEL_W-1:0] SP_SEL      = SEL_W'(SP_IDX);
    localparam bit               SP_WRITABLE = (SP_IDX >= NUM_CONST);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;
    logic             wr_rej;
    logic             sp_act;
    logic [WIDTH-1:0] sp_next;
    logic [WIDTH-1:0] rd_a_nxt;
    logic [WIDTH-1:0] rd_b_nxt;

    function automatic logic [WIDTH-1:0] reset_val(input int idx);
        case (idx)
            1:       return WIDTH'(1);
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return '1;
            default: return '0;
        endcase
    endfunction

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return {1'b0, sel} < DEPTH_L;
    endfunction

    assign wr_ok  = bus.wr_en && ({1'b0, bus.wr_sel} >= NUM_CONST_L) && in_range(bus.wr_sel);
    assign wr_rej = bus.wr_en && !wr_ok;

    // An explicit write to the stack pointer overrides a same-cycle adjust.
    assign sp_act  = SP_WRITABLE && (bus.sp_op == 2'b01 || bus.sp_op == 2'b10) &&
                     !(wr_ok && bus.wr_sel == SP_SEL);
    assign sp_next = (bus.sp_op == 2'b01) ? regs[SP_IDX] + WIDTH'(1) : regs[SP_IDX] - WIDTH'(1);

    // Read muxes see the value the register will hold after this edge.
    always_comb begin
        rd_a_nxt = regs[bus.rd_sel_a];
        if (wr_ok && bus.rd_sel_a == bus.wr_sel)
            rd_a_nxt = bus.wr_data;
        else if (sp_act && bus.rd_sel_a == SP_SEL)
            rd_a_nxt = sp_next;
        if (!in_range(bus.rd_sel_a))
            rd_a_nxt = '0;

        rd_b_nxt = regs[bus.rd_sel_b];
        if (wr_ok && bus.rd_sel_b == bus.wr_sel)
            rd_b_nxt = bus.wr_data;
        else if (sp_act && bus.rd_sel_b == SP_SEL)
            rd_b_nxt = sp_next;
        if (!in_range(bus.rd_sel_b))
            rd_b_nxt = '0;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        logic [WIDTH-1:0] q;
        always_ff @(posedge clk or posedge clear) begin
            if (clear)
                q <= reset_val(g);
            else if (wr_ok && bus.wr_sel == SEL_W'(g))
                q <= bus.wr_data;
            else if (g == SP_IDX && sp_act)
                q <= sp_next;
        end
        assign regs[g] = q;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            bus.rd_data_a <= '0;
            bus.rd_data_b <= '0;
            bus.wr_err    <= 1'b0;
        end else begin
            if (bus.rd_en_a)
                bus.rd_data_a <= rd_a_nxt;
            if (bus.rd_en_b)
                bus.rd_data_b <= rd_b_nxt;
            bus.wr_err <= wr_rej;
        end
    end

    assign bus.sp_out  = regs[SP_IDX];
    assign bus.dbg_out = regs[DBG_IDX];
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomised and directed bench for reg_file_2r1w against an array-based
// model whose reads observe the post-edge register contents.
module tb_reg_file_2r1w;
    localparam int WIDTH     = 16;
    localparam int DEPTH     = 48;
    localparam int SEL_W     = 6;
    localparam int NUM_CONST = 4;
    localparam int SP_IDX    = 4;
    localparam int DBG_IDX   = 8;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    reg_file_2r1w_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    reg_file_2r1w #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W),
        .NUM_CONST(NUM_CONST), .SP_IDX(SP_IDX), .DBG_IDX(DBG_IDX)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m [DEPTH];
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_err;
    logic [15:0] cv [4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = 16'h0000;
        m[1] = 16'h0001;
        m[2] = 16'h8000;
        m[3] = 16'hFFFF;
        exp_a   = 16'h0000;
        exp_b   = 16'h0000;
        exp_err = 1'b0;
    endtask

    task automatic check_outputs();
        check_val("rd_a", bus.rd_data_a, exp_a);
        check_val("rd_b", bus.rd_data_b, exp_b);
        check_val("wr_err", bus.wr_err, exp_err);
        check_val("sp_out", bus.sp_out, m[SP_IDX]);
        check_val("dbg_out", bus.dbg_out, m[DBG_IDX]);
    endtask

    // Apply one cycle of stimulus from a negedge, update the model at the
    // posedge, compare at the following negedge.
    task automatic step(input logic ea, input int sa, input logic eb, input int sb,
                        input logic we, input int ws, input logic [15:0] wd,
                        input logic [1:0] sp);
        logic [15:0] nm [DEPTH];
        logic        ok;
        bus.rd_en_a  = ea;
        bus.rd_sel_a = 6'(sa);
        bus.rd_en_b  = eb;
        bus.rd_sel_b = 6'(sb);
        bus.wr_en    = we;
        bus.wr_sel   = 6'(ws);
        bus.wr_data  = wd;
        bus.sp_op    = sp;
        @(posedge clk);
        nm = m;
        ok = we && ws >= NUM_CONST && ws < DEPTH;
        if (ok) nm[ws] = wd;
        if ((sp == 2'b01 || sp == 2'b10) && !(ok && ws == SP_IDX))
            nm[SP_IDX] = (sp == 2'b01) ? m[SP_IDX] + 16'd1 : m[SP_IDX] - 16'd1;
        if (ea) exp_a = (sa < DEPTH) ? nm[sa] : 16'h0000;
        if (eb) exp_b = (sb < DEPTH) ? nm[sb] : 16'h0000;
        exp_err = we && !ok;
        m = nm;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int ws, sa, sb;
        cv[0] = 16'h0000; cv[1] = 16'h0001; cv[2] = 16'h8000; cv[3] = 16'hFFFF;
        clear        = 1'b1;
        bus.rd_en_a  = 1'b0; bus.rd_sel_a = '0;
        bus.rd_en_b  = 1'b0; bus.rd_sel_b = '0;
        bus.wr_en    = 1'b0; bus.wr_sel   = '0; bus.wr_data = '0;
        bus.sp_op    = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        clear = 1'b0;

        // constants, A ascending and B descending
        for (int i = 0; i < 4; i++) begin
            step(1, i, 1, 3 - i, 0, 0, 16'h0, 2'b00);
            check_val("const_a", bus.rd_data_a, cv[i]);
            check_val("const_b", bus.rd_data_b, cv[3 - i]);
        end
        step(1, 5, 1, 30, 0, 0, 16'h0, 2'b00);

        // plain write then read, then hold
        step(0, 0, 0, 0, 1, 10, 16'h1234, 2'b00);
        step(1, 10, 1, 10, 0, 0, 16'h0, 2'b00);
        check_val("wr_rd_a", bus.rd_data_a, 32'h1234);
        check_val("wr_rd_b", bus.rd_data_b, 32'h1234);
        step(0, 3, 0, 2, 0, 0, 16'h0, 2'b00);
        check_val("hold_a", bus.rd_data_a, 32'h1234);

        // same-cycle bypass
        step(1, 20, 1, 21, 1, 20, 16'hBEEF, 2'b00);
        check_val("byp_a", bus.rd_data_a, 32'hBEEF);
        check_val("byp_b", bus.rd_data_b, 32'h0000);

        // rejected writes: constant and out of range
        step(0, 0, 0, 0, 1, 2, 16'h5555, 2'b00);
        check_val("err_const", bus.wr_err, 32'h1);
        step(1, 2, 0, 0, 0, 0, 16'h0, 2'b00);
        check_val("err_clr", bus.wr_err, 32'h0);
        check_val("const_kept", bus.rd_data_a, 32'h8000);
        step(1, 63, 1, 63, 1, 63, 16'hA5A5, 2'b00);
        check_val("err_oor", bus.wr_err, 32'h1);
        check_val("oor_rd", bus.rd_data_a, 32'h0000);

        // stack pointer wrap and write priority
        step(0, 0, 0, 0, 0, 0, 16'h0, 2'b10);
        check_val("sp_dec", bus.sp_out, 32'hFFFF);
        step(0, 0, 0, 0, 0, 0, 16'h0, 2'b01);
        check_val("sp_inc", bus.sp_out, 32'h0000);
        step(1, SP_IDX, 0, 0, 1, SP_IDX, 16'h0100, 2'b01);
        check_val("sp_wr_wins", bus.sp_out, 32'h0100);
        check_val("sp_wr_byp", bus.rd_data_a, 32'h0100);
        step(0, 0, 1, SP_IDX, 0, 0, 16'h0, 2'b01);
        check_val("sp_byp", bus.rd_data_b, 32'h0101);
        step(0, 0, 0, 0, 0, 0, 16'h0, 2'b11);

        // asynchronous reset in the middle of a cycle with a write pending
        step(1, 8, 0, 0, 1, 8, 16'h7777, 2'b00);
        check_val("dbg_wr", bus.dbg_out, 32'h7777);
        bus.wr_en = 1'b1; bus.wr_sel = 6'd9; bus.wr_data = 16'hAAAA;
        bus.rd_en_a = 1'b1; bus.rd_sel_a = 6'd9;
        bus.rd_en_b = 1'b1; bus.rd_sel_b = 6'd8;
        bus.sp_op = 2'b01;
        #2 clear = 1'b1;
        #1 model_reset();
        check_outputs();
        check_val("clr_dbg", bus.dbg_out, 32'h0000);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        clear = 1'b0;
        step(1, 9, 1, 8, 0, 0, 16'h0, 2'b00);
        check_val("clr_r9", bus.rd_data_a, 32'h0000);
        step(1, 2, 1, 3, 0, 0, 16'h0, 2'b00);
        check_val("clr_c2", bus.rd_data_a, 32'h8000);
        check_val("clr_c3", bus.rd_data_b, 32'hFFFF);

        // random traffic with biased collisions
        for (int n = 0; n < 400; n++) begin
            ws = int'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) ws = SP_IDX;
            sa = ($urandom_range(0, 2) == 0) ? ws : int'($urandom_range(0, 63));
            sb = ($urandom_range(0, 2) == 0) ? ws : int'($urandom_range(0, 63));
            step(1'($urandom_range(0, 1)), sa, 1'($urandom_range(0, 1)), sb,
                 1'($urandom_range(0, 1)), ws, 16'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the single-port processor register file.
- Two independent registered read ports and one write port per cycle, so an ALU instruction fetches both operands in one cycle.
- Hardwired read-only constant registers, write-protection error flag, same-cycle write-to-read bypass, and an in-place stack-pointer adjust port for push/pop.
- Sits between decode and ALU in the multi-cycle core.

Parameters:
- WIDTH, 16, bits per register.
- DEPTH, 64, number of registers.
- SEL_W, 6, select width; must satisfy 2**SEL_W >= DEPTH.
- NUM_CONST, 4, registers 0..NUM_CONST-1 are read-only constants.
- SP_IDX, 4, index of the stack pointer register.
- DBG_IDX, 8, index exposed on the debug port.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clear  in  1  asynchronous active-high reset.
- rd_en_a  in  1  read port A enable.
- rd_sel_a  in  SEL_W  read port A register select.
- rd_data_a  out  WIDTH  read port A data (registered).
- rd_en_b  in  1  read port B enable.
- rd_sel_b  in  SEL_W  read port B register select.
- rd_data_b  out  WIDTH  read port B data (registered).
- wr_en  in  1  write enable.
- wr_sel  in  SEL_W  write register select.
- wr_data  in  WIDTH  write data.
- sp_op  in  2  stack pointer adjust: 00 none, 01 increment, 10 decrement, 11 reserved (no-op).
- wr_err  out  1  one-cycle pulse on a rejected write.
- sp_out  out  WIDTH  combinational view of registers[SP_IDX].
- dbg_out  out  WIDTH  combinational view of registers[DBG_IDX].

Behaviour:
- Reset: while clear=1, asynchronously and immediately:
  - register 0 = 0, register 1 = 1, register 2 = 1 followed by WIDTH-1 zeros (MSB only), register 3 = all ones;
  - all other registers = 0;
  - rd_data_a = rd_data_b = 0, wr_err = 0.
  - Constants beyond index 3 (when NUM_CONST > 4) reset to 0 and stay read-only.
- Reset mid-operation: any write, read or sp_op in the same edge as clear=1 is discarded. First effective edge is the first rising clk after clear falls.
- Read latency: 1 cycle.
  - rd_en_x=1 at edge N → rd_data_x valid after edge N and held until the next enabled read.
  - rd_en_x=0 → rd_data_x holds its previous value.
- Bypass (write-first): a read at edge N whose rd_sel equals wr_sel of an accepted write at edge N returns wr_data.
  - Applies independently to both ports.
  - Also applies to the new SP value when rd_sel=SP_IDX and sp_op is active.
- Out-of-range select (sel >= DEPTH):
  - read returns 0;
  - write is rejected with wr_err.
- Write acceptance: wr_en=1 and NUM_CONST <= wr_sel < DEPTH → registers[wr_sel] <= wr_data.
- Rejected write (constant index or out of range): no register changes; wr_err=1 for exactly the following cycle.
- wr_err clears the next cycle unless another rejected write occurs.
- SP adjust: sp_op=01 → SP <= SP+1; sp_op=10 → SP <= SP-1.
  - Modulo 2**WIDTH: 0-1 = all ones, all ones+1 = 0.
- Simultaneous wr_en to SP_IDX and active sp_op: the explicit write wins and sp_op is ignored. Bypass returns wr_data.
- Both read ports may select the same register.
- No state machine beyond the register array and the output/flag registers. All updates are synchronous except reset.

Test Plan:
- Reset then read regs 0..3 on port A and 3..0 on port B → A: 0x0000, 0x0001, 0x8000, 0xFFFF; B reversed; all others read 0x0000.
- Write 0x1234 to reg 10, next cycle read reg 10 on A and B → both 0x1234 after one cycle; rd_en low afterwards → outputs hold 0x1234.
- In one cycle write 0xBEEF to reg 20 and read reg 20 on A → rd_data_a=0xBEEF next cycle (bypass); B reading reg 21 same cycle → 0x0000.
- Write 0x5555 to reg 2 → wr_err=1 for one cycle, reg 2 still reads 0x8000. Write to sel 63 with DEPTH=48 → wr_err=1, read of 63 returns 0.
- SP=0, sp_op=10 → sp_out=0xFFFF; sp_op=01 → 0x0000. Same cycle: wr_en to SP_IDX with 0x0100 and sp_op=01 → sp_out=0x0100.
- Write 0x7777 to reg 8, assert clear mid-cycle with wr_en=1 to reg 9 → dbg_out=0, reg 9=0, rd_data_a/b=0 immediately, constants restored.
